// File: rtl/vms_pkg.sv
// Shared types and helpers for the vector memory sequencer.
package vms_pkg;

  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} vms_state_t;

  function automatic int idx_w(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/vms_addr_gen.sv
// Element address accumulator: loads the base, then adds the stride per step.
// VMS_STRIDE_EN selects the programmable stride; otherwise it is a unit incrementer.
module vms_addr_gen #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] incr;

`ifdef VMS_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= '0;
    end else if (load_i) begin
      stride_q <= stride_i;
    end
  end

  assign incr = stride_q;
`else
  // The stride port is kept for interface compatibility but has no effect here.
  logic unused_stride;
  assign unused_stride = ^stride_i;
  assign incr = ADDR_W'(1);
`endif

  // Accumulating instead of multiplying idx by stride; wrap-around is intended.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_i) begin
      addr_d = addr_q + incr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: moves LANES elements between the pipeline and the
// element-wide data RAM, one per cycle. Optional stride support via VMS_STRIDE_EN.
module vec_mem_sequencer
  import vms_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 19,
  parameter int REG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [LANES*ELEM_W-1:0] store_data,
  input  logic [REG_W-1:0]        rd_in,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*ELEM_W-1:0] load_data,
  output logic [REG_W-1:0]        rd_out
);

  localparam int IW = idx_w(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  vms_state_t                   state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [LANES-1:0][ELEM_W-1:0] store_q, store_d;
  logic [LANES-1:0][ELEM_W-1:0] load_q, load_d;
  logic [REG_W-1:0]             rd_q, rd_d;
  logic                         cap_q;
  logic [IW-1:0]                cap_idx_q;
  logic                         accept;
  logic                         issuing;
  logic [ADDR_W-1:0]            gen_addr;

  assign accept  = (state_q == IDLE) && start;
  assign issuing = (state_q == STORE) || (state_q == LOAD);

  vms_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .step_i  (issuing),
    .base_i  (base_addr),
    .stride_i(stride),
    .addr_o  (gen_addr)
  );

  // RAM data for lane j arrives one cycle after its address, so capture is delayed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    store_d = store_q;
    load_d  = load_q;
    rd_d    = rd_q;
    if (cap_q) begin
      load_d[cap_idx_q] = mem_rdata;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          store_d = store_data;
          idx_d   = '0;
          if (is_store) begin
            state_d = STORE;
          end else begin
            state_d = LOAD;
            load_d  = '0;
            rd_d    = rd_in;
          end
        end
      end
      STORE: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + IW'(1);
      end
      LOAD: begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   idx_d   = idx_q + IW'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      store_q   <= '0;
      load_q    <= '0;
      rd_q      <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      store_q   <= store_d;
      load_q    <= load_d;
      rd_q      <= rd_d;
      cap_q     <= (state_q == LOAD);
      cap_idx_q <= idx_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_wren  = (state_q == STORE);
  assign mem_addr  = issuing ? gen_addr : '0;
  assign mem_wdata = (state_q == STORE) ? store_q[idx_q] : '0;
  assign load_data = load_q;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer with a behavioural RAM and reference model.
module tb_vec_mem_sequencer;

  localparam int LANES  = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 19;
  localparam int REG_W  = 5;

  typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    is_store = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [ADDR_W-1:0]       stride = '0;
  logic [LANES*ELEM_W-1:0] store_data = '0;
  logic [REG_W-1:0]        rd_in = '0;
  logic [ELEM_W-1:0]       mem_rdata = '0;
  logic [ADDR_W-1:0]       mem_addr;
  logic [ELEM_W-1:0]       mem_wdata;
  logic                    mem_wren;
  logic                    busy;
  logic                    done;
  logic [LANES*ELEM_W-1:0] load_data;
  logic [REG_W-1:0]        rd_out;

  int total = 0;
  int bad = 0;

  logic [15:0]             salt = '0;
  logic [ADDR_W+ELEM_W-1:0] wlog[$];
  vec_t                    model_ld = '0;
  logic [REG_W-1:0]        model_rd = '0;

  vec_mem_sequencer #(
    .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .store_data(store_data),
    .rd_in(rd_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .busy(busy), .done(done),
    .load_data(load_data), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // RAM model: read data is the registered address (low bits) xor a per-test salt.
  always @(posedge clk) begin
    mem_rdata <= mem_addr[15:0] ^ salt;
    if (!rst && mem_wren) wlog.push_back({mem_addr, mem_wdata});
  end

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] s,
                                                 input int j);
    longint eff;
    longint t;
`ifdef VMS_STRIDE_EN
    eff = longint'(s);
`else
    eff = (s === s) ? 1 : 1;
`endif
    t = (longint'(b) + longint'(j) * eff) % (longint'(1) << ADDR_W);
    return t[ADDR_W-1:0];
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < LANES; j++) v[j] = ELEM_W'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_store = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, mem_wren, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, mem_wren, mem_addr, mem_wdata});
    end
    total++;
    if (load_data !== '0 || rd_out !== '0) begin
      bad++;
      $display("FAIL reset_regs got ld=%h rd=%h exp 0", load_data, rd_out);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy got=%b exp=0", busy);
    end
    model_ld = '0;
    model_rd = '0;
  endtask

  task automatic run_store(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                           input vec_t sd, input bit keep, input string nm);
    logic [ADDR_W-1:0] ea;
    base_addr = b; stride = s; store_data = sd; is_store = 1'b1; start = 1'b1;
    tick();
    start = keep;
    if (!keep) store_data = rand_vec();
    for (int c = 1; c <= LANES; c++) begin
      ea = exp_addr(b, s, c - 1);
      total++;
      if ({busy, done, mem_wren, mem_addr, mem_wdata} !== {3'b101, ea, sd[c-1]}) begin
        bad++;
        $display("FAIL %s cyc%0d got b/d/w=%b%b%b a=%h d=%h exp 101 a=%h d=%h", nm, c,
                 busy, done, mem_wren, mem_addr, mem_wdata, ea, sd[c-1]);
      end
      tick();
    end
    total++;
    if ({busy, done, mem_wren, mem_addr, mem_wdata} !== {3'b110, {(ADDR_W+ELEM_W){1'b0}}}) begin
      bad++;
      $display("FAIL %s done_cycle got b/d/w=%b%b%b a=%h d=%h exp 110 0 0", nm,
               busy, done, mem_wren, mem_addr, mem_wdata);
    end
    total++;
    if (load_data !== model_ld || rd_out !== model_rd) begin
      bad++;
      $display("FAIL %s load_hold got rd=%h exp rd=%h", nm, rd_out, model_rd);
    end
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got busy=%b done=%b exp 0 0", nm, busy, done);
    end
  endtask

  task automatic run_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                          input logic [REG_W-1:0] rd, input logic [15:0] sl,
                          input int pulse_at, input string nm);
    logic [ADDR_W-1:0] ea;
    vec_t exp_v;
    salt = sl;
    for (int j = 0; j < LANES; j++) begin
      ea = exp_addr(b, s, j);
      exp_v[j] = ea[15:0] ^ sl;
    end
    base_addr = b; stride = s; rd_in = rd; is_store = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    rd_in = REG_W'($urandom);
    for (int c = 1; c <= LANES; c++) begin
      if (c == pulse_at) begin
        start = 1'b1; is_store = 1'b1; base_addr = ADDR_W'($urandom);
      end else begin
        start = 1'b0;
      end
      ea = exp_addr(b, s, c - 1);
      total++;
      if ({busy, done, mem_wren, mem_addr, mem_wdata} !== {3'b100, ea, {ELEM_W{1'b0}}}) begin
        bad++;
        $display("FAIL %s cyc%0d got b/d/w=%b%b%b a=%h d=%h exp 100 a=%h d=0", nm, c,
                 busy, done, mem_wren, mem_addr, mem_wdata, ea);
      end
      if (c == 1) begin
        total++;
        if (load_data !== '0) begin
          bad++;
          $display("FAIL %s clear_on_start got=%h exp=0", nm, load_data);
        end
      end
      tick();
    end
    start = 1'b0;
    total++;
    if ({busy, done, mem_wren, mem_addr, mem_wdata} !== {3'b100, {(ADDR_W+ELEM_W){1'b0}}}) begin
      bad++;
      $display("FAIL %s drain got b/d/w=%b%b%b a=%h exp 100 a=0", nm,
               busy, done, mem_wren, mem_addr);
    end
    tick();
    total++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL %s done got busy=%b done=%b exp 1 1", nm, busy, done);
    end
    total++;
    if (load_data !== exp_v) begin
      bad++;
      $display("FAIL %s load_data got=%h exp=%h", nm, load_data, exp_v);
    end
    total++;
    if (rd_out !== rd) begin
      bad++;
      $display("FAIL %s rd_out got=%h exp=%h", nm, rd_out, rd);
    end
    model_ld = exp_v;
    model_rd = rd;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got busy=%b exp=0", nm, busy);
    end
  endtask

  task automatic test_store_basic();
    vec_t v;
    for (int j = 0; j < LANES; j++) v[j] = ELEM_W'(j);
    run_store(19'h00100, 19'd1, v, 1'b0, "store_basic");
  endtask

  task automatic test_load_stride();
    run_load(19'h00200, 19'd4, 5'd7, 16'h0000, 0, "load_stride4");
  endtask

  task automatic test_wrap();
    run_store(19'h7FFFE, 19'd1, rand_vec(), 1'b0, "store_wrap");
    run_load(19'h7FFF8, 19'h7FFFF, REG_W'($urandom), 16'($urandom), 0, "load_wrap");
  endtask

  task automatic test_start_mid_load();
    run_load(19'h01000, 19'd3, 5'd12, 16'h5A5A, 6, "load_midstart");
  endtask

  task automatic test_start_in_done();
    logic [ADDR_W-1:0] ea;
    run_store(19'h00300, 19'd2, rand_vec(), 1'b1, "store_held");
    tick();
    ea = exp_addr(19'h00300, 19'd2, 0);
    total++;
    if ({busy, mem_wren, mem_addr} !== {2'b11, ea}) begin
      bad++;
      $display("FAIL restart_after_idle got b/w=%b%b a=%h exp 11 a=%h", busy, mem_wren, mem_addr, ea);
    end
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ld = '0;
    model_rd = '0;
  endtask

  task automatic test_reset_mid_store();
    vec_t v;
    logic [ADDR_W-1:0] ea;
    run_load(19'h00400, 19'd1, 5'd9, 16'h1234, 0, "load_pre_reset");
    v = rand_vec();
    wlog.delete();
    base_addr = 19'h00500; stride = 19'd2; store_data = v; is_store = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ld = '0;
    model_rd = '0;
    total++;
    if ({busy, done, mem_wren, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL rst_mid outputs got b/d/w=%b%b%b a=%h exp 0", busy, done, mem_wren, mem_addr);
    end
    total++;
    if (load_data !== '0 || rd_out !== '0) begin
      bad++;
      $display("FAIL rst_mid regs got rd=%h ld_nonzero=%b exp 0", rd_out, |load_data);
    end
    total++;
    if (wlog.size() !== 4) begin
      bad++;
      $display("FAIL rst_mid write_count got=%0d exp=4", wlog.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        ea = exp_addr(19'h00500, 19'd2, j);
        total++;
        if (wlog[j] !== {ea, v[j]}) begin
          bad++;
          $display("FAIL rst_mid write%0d got=%h exp=%h", j, wlog[j], {ea, v[j]});
        end
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_store(ADDR_W'($urandom), ADDR_W'($urandom), rand_vec(), 1'b0, "rand_store");
      run_load(ADDR_W'($urandom), ADDR_W'($urandom), REG_W'($urandom), 16'($urandom), 0, "rand_load");
    end
  endtask

  task automatic test_back_to_back();
    run_load(19'h02000, 19'd8, 5'd3, 16'hBEEF, 0, "b2b_load");
    start = 1'b0;
    run_store(19'h03000, 19'd5, rand_vec(), 1'b0, "b2b_store");
    run_load(19'h04000, 19'd1, 5'd30, 16'h0F0F, 0, "b2b_load2");
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_load_stride();
    test_wrap();
    test_start_mid_load();
    test_start_in_done();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
